// File: rtl/bcd_share_arb.sv
// Time-shared two's-complement to 2-digit BCD converter with round-robin req/ack arbitration.
// Define BCD_BLANK_EN to report a leading-zero tens digit as 4'hF (display blank).
module bcd_share_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] val_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] val_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             done,
  output logic             owner,
  output logic             busy,
  output logic             neg,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = WIDTH + 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] mag, mag_nxt;
  logic [3:0]       sd_h, sd_t, sd_o, sd_h_nxt, sd_t_nxt, sd_o_nxt;
  logic             sign, sign_nxt, nz, nz_nxt;
  logic             gnt_b, gnt_b_nxt, last_b, last_b_nxt;
  logic             ack_a_nxt, ack_b_nxt, done_nxt, owner_nxt, busy_nxt;
  logic             neg_nxt, ovf_nxt;
  logic [3:0]       tens_nxt, ones_nxt;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Arbitration and absolute value of the candidate request
  logic             sel_b;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH:0]   sel_ext, abs_full;

  always_comb begin
    sel_b    = (req_a && req_b) ? ~last_b : req_b;
    sel_val  = sel_b ? val_b : val_a;
    sel_ext  = {sel_val[WIDTH-1], sel_val};
    abs_full = sel_val[WIDTH-1] ? (~sel_ext + (WIDTH+1)'(1)) : sel_ext;
  end

  // One double-dabble step: adjust digits, then shift the whole scratch word left
  logic [SW-1:0] sh;
  logic [3:0]    h_sh, t_sh, o_sh;
  logic          ovf_res;
  logic [3:0]    tens_res, ones_res;

  always_comb begin
    sh       = {add3(sd_h), add3(sd_t), add3(sd_o), mag} << 1;
    h_sh     = sh[SW-1 -: 4];
    t_sh     = sh[SW-5 -: 4];
    o_sh     = sh[SW-9 -: 4];
    ovf_res  = (h_sh != 4'd0);
    tens_res = ovf_res ? 4'd9 : t_sh;
    ones_res = ovf_res ? 4'd9 : o_sh;
`ifdef BCD_BLANK_EN
    if (!ovf_res && (t_sh == 4'd0)) tens_res = 4'hF;
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mag_nxt    = mag;
    sd_h_nxt   = sd_h;
    sd_t_nxt   = sd_t;
    sd_o_nxt   = sd_o;
    sign_nxt   = sign;
    nz_nxt     = nz;
    gnt_b_nxt  = gnt_b;
    last_b_nxt = last_b;
    ack_a_nxt  = 1'b0;
    ack_b_nxt  = 1'b0;
    done_nxt   = 1'b0;
    owner_nxt  = owner;
    neg_nxt    = neg;
    tens_nxt   = tens;
    ones_nxt   = ones;
    ovf_nxt    = ovf;
    case (state)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_nxt  = S_SHIFT;
          gnt_b_nxt  = sel_b;
          last_b_nxt = sel_b;
          sign_nxt   = sel_val[WIDTH-1];
          nz_nxt     = |abs_full;
          mag_nxt    = abs_full[WIDTH-1:0];
          sd_h_nxt   = 4'd0;
          sd_t_nxt   = 4'd0;
          sd_o_nxt   = 4'd0;
          cnt_nxt    = CW'(0);
        end
      end
      S_SHIFT: begin
        sd_h_nxt = h_sh;
        sd_t_nxt = t_sh;
        sd_o_nxt = o_sh;
        mag_nxt  = sh[WIDTH-1:0];
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = S_DONE;
          ack_a_nxt = ~gnt_b;
          ack_b_nxt = gnt_b;
          done_nxt  = 1'b1;
          owner_nxt = gnt_b;
          neg_nxt   = sign & nz;
          tens_nxt  = tens_res;
          ones_nxt  = ones_res;
          ovf_nxt   = ovf_res;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= CW'(0);
      mag    <= '0;
      sd_h   <= 4'd0;
      sd_t   <= 4'd0;
      sd_o   <= 4'd0;
      sign   <= 1'b0;
      nz     <= 1'b0;
      gnt_b  <= 1'b0;
      last_b <= 1'b1;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      done   <= 1'b0;
      owner  <= 1'b0;
      busy   <= 1'b0;
      neg    <= 1'b0;
      tens   <= 4'd0;
      ones   <= 4'd0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mag    <= mag_nxt;
      sd_h   <= sd_h_nxt;
      sd_t   <= sd_t_nxt;
      sd_o   <= sd_o_nxt;
      sign   <= sign_nxt;
      nz     <= nz_nxt;
      gnt_b  <= gnt_b_nxt;
      last_b <= last_b_nxt;
      ack_a  <= ack_a_nxt;
      ack_b  <= ack_b_nxt;
      done   <= done_nxt;
      owner  <= owner_nxt;
      busy   <= busy_nxt;
      neg    <= neg_nxt;
      tens   <= tens_nxt;
      ones   <= ones_nxt;
      ovf    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_share_arb.sv
// Bench for bcd_share_arb: countdown/arithmetic reference model checked every cycle,
// plus directed conversions with literal expected digits, latencies and arbitration order.
module tb_bcd_share_arb;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_a, req_b;
  logic [WIDTH-1:0] val_a, val_b;
  logic             ack_a, ack_b, done, owner, busy, neg, ovf;
  logic [3:0]       tens, ones;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  bcd_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .ack_a(ack_a), .ack_b(ack_b), .done(done), .owner(owner), .busy(busy),
    .neg(neg), .tens(tens), .ones(ones), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tz();
`ifdef BCD_BLANK_EN
    return 15;
`else
    return 0;
`endif
  endfunction

  // Reference model: a busy countdown plus integer arithmetic for the digits
  int m_timer;
  bit m_last_b, m_cur_b;
  int m_v, m_mag;
  int m_owner, m_neg, m_tens, m_ones, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_timer = 0; m_last_b = 1'b1; m_cur_b = 1'b0; m_v = 0;
      m_owner = 0; m_neg = 0; m_tens = 0; m_ones = 0; m_ovf = 0;
    end else if (m_timer == 0) begin
      if (req_a || req_b) begin
        m_cur_b  = (req_a && req_b) ? !m_last_b : req_b;
        m_v      = m_cur_b ? int'($signed(val_b)) : int'($signed(val_a));
        m_last_b = m_cur_b;
        m_timer  = WIDTH + 1;
      end
    end else begin
      m_timer--;
      if (m_timer == 1) begin
        m_mag   = (m_v < 0) ? -m_v : m_v;
        m_ovf   = (m_mag > 99) ? 1 : 0;
        m_tens  = m_ovf ? 9 : m_mag / 10;
        m_ones  = m_ovf ? 9 : m_mag % 10;
        if (!m_ovf && m_tens == 0) m_tens = tz();
        m_neg   = (m_v < 0) ? 1 : 0;
        m_owner = m_cur_b ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ack_a", ack_a, (m_timer == 1) && !m_cur_b);
      chk("m_ack_b", ack_b, (m_timer == 1) && m_cur_b);
      chk("m_done",  done,  m_timer == 1);
      chk("m_busy",  busy,  m_timer != 0);
      chk("m_owner", owner, m_owner);
      chk("m_neg",   neg,   m_neg);
      chk("m_tens",  tens,  m_tens);
      chk("m_ones",  ones,  m_ones);
      chk("m_ovf",   ovf,   m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack_a"}, ack_a, 0);
    chk({tag, "_ack_b"}, ack_b, 0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_neg"},   neg,   0);
    chk({tag, "_tens"},  tens,  0);
    chk({tag, "_ones"},  ones,  0);
    chk({tag, "_ovf"},   ovf,   0);
  endtask

  task automatic expect_res(input string tag, input int t, input int o, input int n,
                            input int v, input int ow);
    chk({tag, "_tens"},  tens,  t);
    chk({tag, "_ones"},  ones,  o);
    chk({tag, "_neg"},   neg,   n);
    chk({tag, "_ovf"},   ovf,   v);
    chk({tag, "_owner"}, owner, ow);
  endtask

  // Issue one request from an idle DUT and wait (bounded) for its ack
  task automatic conv(input string tag, input bit use_b, input logic [WIDTH-1:0] v);
    int lat;
    if (use_b) begin req_b = 1'b1; val_b = v; end
    else       begin req_a = 1'b1; val_a = v; end
    tick();
    chk({tag, "_busy_rise"}, busy, 1);
    lat = -1;
    for (int k = 1; k <= WIDTH + 6; k++) begin
      tick();
      if (use_b ? ack_b : ack_a) begin lat = k; break; end
    end
    if (use_b) req_b = 1'b0; else req_a = 1'b0;
    chk({tag, "_latency"}, lat, WIDTH);
  endtask

  task automatic after_ack(input string tag);
    tick();
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_done_low"},  done, 0);
  endtask

  int d_cyc[4];
  bit d_b[4];
  int nd;
  int lat_b;

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; val_a = '0; val_b = '0;
    repeat (2) tick();
    chk_zero("rst");
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    tick();

    conv("a42", 1'b0, 8'd42);    expect_res("a42", 4, 2, 0, 0, 0);  after_ack("a42");
    conv("bm39", 1'b1, 8'hD9);   expect_res("bm39", 3, 9, 1, 0, 1); after_ack("bm39");
    conv("am128", 1'b0, 8'h80);  expect_res("am128", 9, 9, 1, 1, 0); after_ack("am128");
    conv("a100", 1'b0, 8'd100);  expect_res("a100", 9, 9, 0, 1, 0); after_ack("a100");
    conv("a0", 1'b0, 8'd0);      expect_res("a0", tz(), 0, 0, 0, 0); after_ack("a0");
    conv("am1", 1'b0, 8'hFF);    expect_res("am1", tz(), 1, 1, 0, 0); after_ack("am1");

    // B arrives during A's SHIFT; B is served right after A completes
    req_a = 1'b1; val_a = 8'd42;
    tick();
    repeat (3) tick();
    req_b = 1'b1; val_b = 8'd99;
    for (int k = 0; k < 20 && !ack_a; k++) tick();
    chk("mid_ack_a", ack_a, 1);
    expect_res("mid_a", 4, 2, 0, 0, 0);
    req_a = 1'b0;
    lat_b = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack_b) begin lat_b = k; break; end
    end
    req_b = 1'b0;
    chk("mid_b_spacing", lat_b, WIDTH + 2);
    expect_res("mid_b", 9, 9, 0, 0, 1);
    after_ack("mid_b");

    // Reset mid-SHIFT discards the conversion
    req_a = 1'b1; val_a = 8'd55;
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    req_a = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("arst_no_ack", ack_a | ack_b | done, 0);
    end
    conv("a7", 1'b0, 8'd7); expect_res("a7", tz(), 7, 0, 0, 0); after_ack("a7");

    // Fresh reset so A wins the first tie; both held high
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_a = 1'b1; val_a = 8'd57; req_b = 1'b1; val_b = 8'hF6;
    nd = 0;
    for (int k = 1; k <= 60 && nd < 4; k++) begin
      tick();
      if (done) begin
        d_cyc[nd] = k;
        d_b[nd]   = ack_b;
        if (ack_b) expect_res("tie_b", 1, 0, 1, 0, 1);
        else       expect_res("tie_a", 5, 7, 0, 0, 0);
        nd++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("tie_count", nd, 4);
    if (nd == 4) begin
      chk("tie_first_cycle", d_cyc[0], WIDTH + 1);
      for (int i = 0; i < 4; i++) chk("tie_order", d_b[i], i % 2);
      for (int i = 1; i < 4; i++) chk("tie_spacing", d_cyc[i] - d_cyc[i-1], WIDTH + 2);
    end
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
